hazard_ctrl: RTL

Pipeline hazard controller for the five-stage RV32I core. It drives the enable/clear controls of the F/D/E/M/W pipeline registers: load-use stalls, taken-branch flushes and multi-cycle data-memory wait stalls. It also produces the E-stage forwarding selects, a saturating stall-cycle performance counter and a sticky memory-timeout flag. Stall outputs are inverted into each pipeline register's `EN`; flush outputs drive its `CLR`.

---
 rtl/hazard_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - RV32I five-stage pipeline hazard controller
module hazard_ctrl #(
  parameter int ADDR_W    = 5,
  parameter int CNT_WIDTH = 32,
  parameter int MAX_WAIT  = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_W-1:0]    Rs1D,
  input  logic [ADDR_W-1:0]    Rs2D,
  input  logic [ADDR_W-1:0]    Rs1E,
  input  logic [ADDR_W-1:0]    Rs2E,
  input  logic [ADDR_W-1:0]    RdE,
  input  logic                 ResultSrcE0,
  input  logic                 PCSrcE,
  input  logic [ADDR_W-1:0]    RdM,
  input  logic                 RegWriteM,
  input  logic [ADDR_W-1:0]    RdW,
  input  logic                 RegWriteW,
  input  logic                 MemReqM,
  input  logic                 MemReadyM,
  output logic                 StallF,
  output logic                 StallD,
  output logic                 StallE,
  output logic                 StallM,
  output logic                 FlushD,
  output logic                 FlushE,
  output logic                 FlushW,
  output logic [1:0]           ForwardAE,
  output logic [1:0]           ForwardBE,
  output logic [CNT_WIDTH-1:0] stall_count,
  output logic                 mem_timeout
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] MAX_CNT = WW'(MAX_WAIT);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t        state;
  logic [WW-1:0] wait_cnt;
  logic [WW-1:0] wait_cnt_next;
  logic          mem_stall;
  logic          lw_stall;

  assign mem_stall = MemReqM & ~MemReadyM;
  assign lw_stall  = ResultSrcE0 & (RdE != '0) & ((RdE == Rs1D) | (RdE == Rs2D)) & ~PCSrcE;

  // Stall/flush decode: memory wait freezes everything and bubbles W, then branch, then load-use
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (!rst_n) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushW = 1'b1;
    end else if (mem_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (PCSrcE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (lw_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  // E-stage operand forwarding; the younger M result wins over W
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (rst_n) begin
      if (RegWriteM && (RdM != '0) && (RdM == Rs1E))
        ForwardAE = 2'b10;
      else if (RegWriteW && (RdW != '0) && (RdW == Rs1E))
        ForwardAE = 2'b01;
      if (RegWriteM && (RdM != '0) && (RdM == Rs2E))
        ForwardBE = 2'b10;
      else if (RegWriteW && (RdW != '0) && (RdW == Rs2E))
        ForwardBE = 2'b01;
    end
  end

  // Wait length the FSM will hold after this edge if the memory stall continues
  always_comb begin
    wait_cnt_next = WW'(1);
    if (state == ST_WAIT)
      wait_cnt_next = (wait_cnt == MAX_CNT) ? MAX_CNT : wait_cnt + WW'(1);
  end

  // Memory-wait FSM with saturating wait counter and sticky timeout flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (mem_stall) begin
            state    <= ST_WAIT;
            wait_cnt <= wait_cnt_next;
          end
        end
        ST_WAIT: begin
          if (mem_stall) begin
            wait_cnt <= wait_cnt_next;
          end else begin
            state    <= ST_RUN;
            wait_cnt <= '0;
          end
        end
        default: begin
          state    <= ST_RUN;
          wait_cnt <= '0;
        end
      endcase
      if (mem_stall && (wait_cnt_next == MAX_CNT))
        mem_timeout <= 1'b1;
    end
  end

  // Saturating count of fetch-stall cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_count <= '0;
    else if (StallF && (stall_count != '1))
      stall_count <= stall_count + CNT_WIDTH'(1);
  end

endmodule
